// File: rtl/fp_pkg.sv
// Shared FP helpers: default widths, operand classes, flag bit positions, canonical qNaN.
package fp_pkg;
  localparam int DEF_EXP_W = 5;
  localparam int DEF_MAN_W = 10;

  typedef enum logic [1:0] {FP_ZERO, FP_NORM, FP_INF, FP_NAN} fpClassE;

  // out_flags = {nan, overflow, underflow, zero}
  localparam int FLG_ZERO = 0;
  localparam int FLG_UNF  = 1;
  localparam int FLG_OVF  = 2;
  localparam int FLG_NAN  = 3;

  function automatic int fpWidth(input int expW, input int manW);
    return 1 + expW + manW;
  endfunction

  function automatic int fpBias(input int expW);
    return (1 << (expW - 1)) - 1;
  endfunction

  function automatic int fpExpMax(input int expW);
    return (1 << expW) - 1;
  endfunction

  function automatic logic [63:0] canonQnan(input int expW, input int manW);
    logic [63:0] r;
    r = ((64'(1) << expW) - 64'(1)) << manW;
    r[manW-1] = 1'b1;
    return r;
  endfunction

  // Subnormals land in FP_ZERO: they are flushed, not multiplied.
  function automatic fpClassE fpClassify(input logic expZero, input logic expOnes,
                                         input logic fracZero);
    if (expZero)       return FP_ZERO;
    else if (!expOnes) return FP_NORM;
    else if (fracZero) return FP_INF;
    else               return FP_NAN;
  endfunction
endpackage

// File: rtl/fp_round_pack.sv
// Final stage of the FP multiplier: optional RNE rounding, range checks, special-value select, pack.
// FPMUL_RNE_EN selects round-to-nearest-even; otherwise the mantissa is truncated.
module fp_round_pack import fp_pkg::*; #(
  parameter int EXP_W = DEF_EXP_W,
  parameter int MAN_W = DEF_MAN_W
) (
  input  logic               sign,
  input  logic               isNan,
  input  logic               isInf,
  input  logic               isZero,
  input  logic [EXP_W+1:0]   esum,
  input  logic [MAN_W-1:0]   mant,
  input  logic               guard,
  input  logic               sticky,
  output logic [EXP_W+MAN_W:0] p,
  output logic [3:0]         flags
);
  localparam int W       = fpWidth(EXP_W, MAN_W);
  localparam int EXP_MAX = fpExpMax(EXP_W);
  localparam logic [W-1:0] QNAN = W'(canonQnan(EXP_W, MAN_W));

  logic [MAN_W-1:0] mantR;
  logic [EXP_W+1:0] expR;
  logic             ovf, unf;

`ifdef FPMUL_RNE_EN
  logic carry, rndUp;
  assign rndUp = guard & (sticky | mant[0]);
  // A carry out of the fraction leaves it all-zero and bumps the exponent.
  assign {carry, mantR} = {1'b0, mant} + (MAN_W+1)'(rndUp);
  assign expR = esum + (EXP_W+2)'(carry);
`else
  logic unusedRnd;
  assign unusedRnd = guard ^ sticky;
  assign mantR = mant;
  assign expR  = esum;
`endif

  // esum is two's complement; the top bit is its sign.
  assign ovf = !expR[EXP_W+1] && (expR[EXP_W:0] >= (EXP_W+1)'(EXP_MAX));
  assign unf = expR[EXP_W+1] || (expR == '0);

  always_comb begin
    p     = {sign, expR[EXP_W-1:0], mantR};
    flags = '0;
    if (isNan || (isInf && isZero)) begin
      p = QNAN;
      flags[FLG_NAN] = 1'b1;
    end else if (isInf) begin
      p = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (isZero) begin
      p = {sign, {(W-1){1'b0}}};
      flags[FLG_ZERO] = 1'b1;
    end else if (ovf) begin
      p = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flags[FLG_OVF] = 1'b1;
    end else if (unf) begin
      p = {sign, {(W-1){1'b0}}};
      flags[FLG_UNF]  = 1'b1;
      flags[FLG_ZERO] = 1'b1;
    end
  end
endmodule

// File: rtl/fp_mul_pipe.sv
// 3-stage pipelined FP multiplier (unpack/multiply, normalise, round/pack) with valid/ready flow.
// FPMUL_RNE_EN enables round-to-nearest-even in fp_round_pack; default build truncates.
module fp_mul_pipe import fp_pkg::*; #(
  parameter int EXP_W = DEF_EXP_W,
  parameter int MAN_W = DEF_MAN_W,
  parameter int TAG_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] in_a,
  input  logic [EXP_W+MAN_W:0] in_b,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] out_p,
  output logic [TAG_W-1:0]     out_tag,
  output logic [3:0]           out_flags
);
  localparam int W      = fpWidth(EXP_W, MAN_W);
  localparam int BIAS   = fpBias(EXP_W);
  localparam int PW     = 2*MAN_W + 2;
  localparam int EPW    = EXP_W + 2;
  localparam int STAGES = 3;

  typedef struct packed {
    logic             sign;
    logic             isNan;
    logic             isInf;
    logic             isZero;
    logic [EPW-1:0]   esum;
    logic [PW-1:0]    prod;
    logic [TAG_W-1:0] tag;
  } s1T;

  typedef struct packed {
    logic             sign;
    logic             isNan;
    logic             isInf;
    logic             isZero;
    logic [EPW-1:0]   esum;
    logic [MAN_W-1:0] mant;
    logic             guard;
    logic             sticky;
    logic [TAG_W-1:0] tag;
  } s2T;

  logic              adv;
  logic [STAGES:1]   vldPipe;
  s1T                s1, s1Next;
  s2T                s2, s2Next;
  fpClassE           clsA, clsB;
  logic [W-1:0]      rpP;
  logic [3:0]        rpFlags;

  // The whole pipe moves as one; a stalled output freezes every stage.
  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;
  assign out_valid = vldPipe[STAGES];

  assign clsA = fpClassify(in_a[W-2:MAN_W] == '0, in_a[W-2:MAN_W] == '1, in_a[MAN_W-1:0] == '0);
  assign clsB = fpClassify(in_b[W-2:MAN_W] == '0, in_b[W-2:MAN_W] == '1, in_b[MAN_W-1:0] == '0);

  always_comb begin
    s1Next.sign   = in_a[W-1] ^ in_b[W-1];
    s1Next.isNan  = (clsA == FP_NAN)  || (clsB == FP_NAN);
    s1Next.isInf  = (clsA == FP_INF)  || (clsB == FP_INF);
    s1Next.isZero = (clsA == FP_ZERO) || (clsB == FP_ZERO);
    s1Next.esum   = EPW'(in_a[W-2:MAN_W]) + EPW'(in_b[W-2:MAN_W]) - EPW'(BIAS);
    s1Next.prod   = PW'({1'b1, in_a[MAN_W-1:0]}) * PW'({1'b1, in_b[MAN_W-1:0]});
    s1Next.tag    = in_tag;
  end

  // Significand product lies in [1,4); a set MSB means one extra exponent step.
  always_comb begin
    s2Next.sign   = s1.sign;
    s2Next.isNan  = s1.isNan;
    s2Next.isInf  = s1.isInf;
    s2Next.isZero = s1.isZero;
    s2Next.tag    = s1.tag;
    if (s1.prod[PW-1]) begin
      s2Next.esum   = s1.esum + EPW'(1);
      s2Next.mant   = s1.prod[2*MAN_W:MAN_W+1];
      s2Next.guard  = s1.prod[MAN_W];
      s2Next.sticky = |s1.prod[MAN_W-1:0];
    end else begin
      s2Next.esum   = s1.esum;
      s2Next.mant   = s1.prod[2*MAN_W-1:MAN_W];
      s2Next.guard  = s1.prod[MAN_W-1];
      s2Next.sticky = |s1.prod[MAN_W-2:0];
    end
  end

  fp_round_pack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) uRoundPack (
    .sign   (s2.sign),
    .isNan  (s2.isNan),
    .isInf  (s2.isInf),
    .isZero (s2.isZero),
    .esum   (s2.esum),
    .mant   (s2.mant),
    .guard  (s2.guard),
    .sticky (s2.sticky),
    .p      (rpP),
    .flags  (rpFlags)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      vldPipe   <= '0;
      out_p     <= '0;
      out_tag   <= '0;
      out_flags <= '0;
    end else if (adv) begin
      vldPipe <= {vldPipe[STAGES-1:1], in_valid};
      if (in_valid)   s1 <= s1Next;
      if (vldPipe[1]) s2 <= s2Next;
      if (vldPipe[2]) begin
        out_p     <= rpP;
        out_tag   <= s2.tag;
        out_flags <= rpFlags;
      end
    end
  end
endmodule

// File: tb/tb_fp_mul_pipe.sv
// Bench for fp_mul_pipe (FP16): directed specials, stall/order, mid-flight reset, random stream vs model.
module tb_fp_mul_pipe;
  localparam int EW = 5;
  localparam int MW = 10;
  localparam int TW = 4;
  localparam int W  = 1 + EW + MW;

  logic          clk = 1'b0;
  logic          rst, in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0]  in_a, in_b, out_p;
  logic [TW-1:0] in_tag, out_tag;
  logic [3:0]    out_flags;

  always #5 clk = ~clk;

  fp_mul_pipe #(.EXP_W(EW), .MAN_W(MW), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_p(out_p), .out_tag(out_tag), .out_flags(out_flags)
  );

  int nChecks = 0;
  int nErr    = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    nChecks++;
    if (got !== want) begin
      nErr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // Reference: exact integer significand product, then round/truncate by comparing the
  // discarded remainder against one half ulp.
  function automatic void refMul(input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] p, output logic [3:0] fl);
    int    emax, bias, ea, eb, e, sh, mant;
    longint prod;
    logic  s;
    bit    za, zb, ia, ib, na, nb;
    emax = (1 << EW) - 1;
    bias = (1 << (EW-1)) - 1;
    s  = a[W-1] ^ b[W-1];
    ea = int'(a[W-2:MW]);
    eb = int'(b[W-2:MW]);
    za = (ea == 0);
    zb = (eb == 0);
    ia = (ea == emax) && (a[MW-1:0] == 0);
    ib = (eb == emax) && (b[MW-1:0] == 0);
    na = (ea == emax) && (a[MW-1:0] != 0);
    nb = (eb == emax) && (b[MW-1:0] != 0);
    fl = 4'b0000;
    if (na || nb || ((ia || ib) && (za || zb))) begin
      p  = {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};
      fl = 4'b1000;
    end else if (ia || ib) begin
      p = {s, {EW{1'b1}}, {MW{1'b0}}};
    end else if (za || zb) begin
      p  = {s, {(W-1){1'b0}}};
      fl = 4'b0001;
    end else begin
      prod = longint'((1 << MW) + int'(a[MW-1:0])) * longint'((1 << MW) + int'(b[MW-1:0]));
      e  = ea + eb - bias;
      sh = MW;
      if (prod >= (longint'(1) << (2*MW+1))) begin
        e++;
        sh = MW + 1;
      end
      mant = int'(prod >> sh) - (1 << MW);
`ifdef FPMUL_RNE_EN
      begin
        longint rem, half;
        rem  = prod - ((prod >> sh) << sh);
        half = longint'(1) << (sh - 1);
        if (rem > half || (rem == half && (mant % 2) == 1)) mant++;
        if (mant == (1 << MW)) begin
          mant = 0;
          e++;
        end
      end
`endif
      if (e >= emax) begin
        p  = {s, {EW{1'b1}}, {MW{1'b0}}};
        fl = 4'b0100;
      end else if (e <= 0) begin
        p  = {s, {(W-1){1'b0}}};
        fl = 4'b0011;
      end else begin
        p = {s, EW'(e), MW'(mant)};
      end
    end
  endfunction

  function automatic logic [W-1:0] randOp();
    logic [W-1:0] v;
    int r;
    v = W'($urandom);
    r = $urandom_range(0, 9);
    if (r == 0)      v[W-2:MW] = '0;
    else if (r == 1) v[W-2:MW] = '1;
    else if (r < 6)  v[W-2:MW] = EW'($urandom_range(8, 22));
    return v;
  endfunction

  typedef struct {
    logic [W-1:0]  p;
    logic [3:0]    f;
    logic [TW-1:0] tag;
    int            acc;
    bit            lat;
  } expT;

  expT q[$];

  // Driver-published expectations for the op currently on the input.
  bit           curUse = 1'b0;
  bit           curLat = 1'b0;
  logic [W-1:0] curP   = '0;
  logic [3:0]   curF   = '0;

  bit            prevStall = 1'b0;
  logic [W-1:0]  hP;
  logic [TW-1:0] hTag;
  logic [3:0]    hF;

  always @(negedge clk) begin : monitor
    expT e;
    if (rst) begin
      q.delete();
      prevStall = 1'b0;
    end else begin
      if (prevStall) begin
        chk("holdValid", out_valid, 1);
        chk("holdP", out_p, hP);
        chk("holdTag", out_tag, hTag);
        chk("holdFlags", out_flags, hF);
      end
      if (out_valid && !out_ready) chk("inReadyStall", in_ready, 0);
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("staleResult", out_valid, 0);
        else begin
          e = q.pop_front();
          chk("product", out_p, e.p);
          chk("tag", out_tag, e.tag);
          chk("flags", out_flags, e.f);
          if (e.lat) chk("latency", cyc - e.acc, 3);
        end
      end
      if (in_valid && in_ready) begin
        e.tag = in_tag;
        e.acc = cyc;
        e.lat = curLat;
        if (curUse) begin
          e.p = curP;
          e.f = curF;
        end else refMul(in_a, in_b, e.p, e.f);
        q.push_back(e);
      end
      prevStall = out_valid && !out_ready;
      hP   = out_p;
      hTag = out_tag;
      hF   = out_flags;
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic sendOp(input logic [W-1:0] a, input logic [W-1:0] b, input logic [TW-1:0] t);
    bit acc;
    acc = 1'b0;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_tag = t;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (in_ready) begin
        acc = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!acc) chk("acceptTimeout", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 200; k++) begin
      if (q.size() == 0 && !out_valid) break;
      @(negedge clk);
    end
    chk("drain", q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  logic [W-1:0] da [8] = '{16'h3E00, 16'h3C05, 16'h7800, 16'h0400,
                           16'hC000, 16'h7C00, 16'h7C01, 16'hFC00};
  logic [W-1:0] db [8] = '{16'h3E00, 16'h3E00, 16'h7800, 16'h3800,
                           16'h0000, 16'h0000, 16'h3C00, 16'h4000};
`ifdef FPMUL_RNE_EN
  logic [W-1:0] dp [8] = '{16'h4080, 16'h3E08, 16'h7C00, 16'h0000,
                           16'h8000, 16'h7E00, 16'h7E00, 16'hFC00};
`else
  logic [W-1:0] dp [8] = '{16'h4080, 16'h3E07, 16'h7C00, 16'h0000,
                           16'h8000, 16'h7E00, 16'h7E00, 16'hFC00};
`endif
  logic [3:0]   df [8] = '{4'b0000, 4'b0000, 4'b0100, 4'b0011,
                           4'b0001, 4'b1000, 4'b1000, 4'b0000};

  bit doneRand = 1'b0;

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    in_tag = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("resetValid", out_valid, 0);
    chk("resetP", out_p, 0);
    chk("resetTag", out_tag, 0);
    chk("resetFlags", out_flags, 0);
    chk("resetInReady", in_ready, 1);
    @(posedge clk);
    #1 rst = 1'b0;

    // Directed operands with fixed expected results, back to back.
    curUse = 1'b1;
    for (int i = 0; i < 8; i++) begin
      curLat = (i == 0);
      curP = dp[i];
      curF = df[i];
      sendOp(da[i], db[i], (i == 0) ? TW'(3) : TW'(i + 8));
    end
    curUse = 1'b0;
    curLat = 1'b0;
    drain();

    // Eight-op stream with a five-cycle downstream stall in the middle.
    fork
      for (int i = 0; i < 8; i++) sendOp(randOp(), randOp(), TW'(i));
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Three ops in flight (one held at the output), then a single reset cycle.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) sendOp(randOp(), randOp(), TW'(i + 1));
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rstMidValid", out_valid, 0);
    chk("rstMidP", out_p, 0);
    chk("rstMidTag", out_tag, 0);
    chk("rstMidFlags", out_flags, 0);
    @(posedge clk);
    #1 out_ready = 1'b1;
    repeat (10) @(negedge clk);
    chk("rstNoStale", out_valid, 0);
    @(posedge clk);
    #1;

    // Random stream with random gaps and random backpressure.
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
          sendOp(randOp(), randOp(), TW'($urandom));
        end
        doneRand = 1'b1;
      end
      begin
        while (!doneRand) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    $display("Result: errors=%0d of %0d checks", nErr, nChecks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
